// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pacman input stage.
// Direction codes, button bit indices and the per-channel debounce state encoding.
package pacman_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t UP    = 2'd0;
  localparam dir_t RIGHT = 2'd1;
  localparam dir_t LEFT  = 2'd2;
  localparam dir_t DOWN  = 2'd3;

  localparam int BTN_UP    = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 2;
  localparam int BTN_DOWN  = 3;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

endpackage

// File: rtl/debounce_ch.sv
// One button channel: two-flop synchronizer, debounce FSM and counter.
// Auto-repeat of the press pulse is built only when BTN_AUTOREPEAT_EN is defined.
module debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_CYCLES   = 6250000
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic pin,
  output logic level,
  output logic press,
  output logic press_set
);
  import pacman_pkg::*;

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);

  logic [1:0]    sync_r;
  logic          s_s;
  deb_state_t    state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          level_r, level_s;
  logic          press_r, press_set_s;

  assign s_s = sync_r[1];

  // Raw pin synchronizer; nothing else samples the pin.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) sync_r <= 2'b00;
    else        sync_r <= {sync_r[0], pin};
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_TERM = RW'(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0] REP_ONE  = RW'(32'd1);
  localparam logic [RW-1:0] REP_ZERO = RW'(32'd0);
  logic [RW-1:0] rep_r, rep_s;
  logic          rep_fire_s;

  // Repeat counter only runs while the button stays accepted and held.
  always_comb begin
    rep_s      = REP_ZERO;
    rep_fire_s = 1'b0;
    if (state_r == PRESSED && s_s) begin
      if (rep_r == REP_TERM) begin
        rep_s      = REP_ZERO;
        rep_fire_s = 1'b1;
      end else begin
        rep_s = rep_r + REP_ONE;
      end
    end else begin
      rep_s = REP_ZERO;
    end
  end

  // Repeat counter register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) rep_r <= REP_ZERO;
    else        rep_r <= rep_s;
  end
`endif

  // Debounce next-state logic; counter saturates at CNT_TERM and never wraps.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    level_s     = level_r;
    press_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        level_s = 1'b0;
        if (s_s) begin
          cnt_s   = CNT_ONE;
          state_s = PRESS_WAIT;
        end else begin
          cnt_s = CNT_ZERO;
        end
      end
      PRESS_WAIT: begin
        if (!s_s) begin
          cnt_s   = CNT_ZERO;
          state_s = IDLE;
        end else if (cnt_r == CNT_TERM) begin
          cnt_s       = CNT_ZERO;
          state_s     = PRESSED;
          level_s     = 1'b1;
          press_set_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      PRESSED: begin
        level_s = 1'b1;
        if (!s_s) begin
          cnt_s   = CNT_ONE;
          state_s = RELEASE_WAIT;
        end else begin
          cnt_s = CNT_ZERO;
`ifdef BTN_AUTOREPEAT_EN
          press_set_s = rep_fire_s;
`endif
        end
      end
      RELEASE_WAIT: begin
        if (s_s) begin
          cnt_s   = CNT_ZERO;
          state_s = PRESSED;
        end else if (cnt_r == CNT_TERM) begin
          cnt_s   = CNT_ZERO;
          state_s = IDLE;
          level_s = 1'b0;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        cnt_s   = CNT_ZERO;
        state_s = IDLE;
        level_s = 1'b0;
      end
    endcase
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      level_r <= 1'b0;
      press_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      level_r <= level_s;
      press_r <= press_set_s;
    end
  end

  assign level     = level_r;
  assign press     = press_r;
  assign press_set = press_set_s;

endmodule

// File: rtl/btn_conditioner.sv
// Four-button conditioner: debounced levels, press pulses and the pac_Direction register.
// Define BTN_AUTOREPEAT_EN to enable held-button auto-repeat in every channel.
module btn_conditioner #(
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter int         REPEAT_CYCLES   = 6250000,
  parameter logic [1:0] UP              = 2'd0,
  parameter logic [1:0] RIGHT           = 2'd1,
  parameter logic [1:0] LEFT            = 2'd2,
  parameter logic [1:0] DOWN            = 2'd3
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       SW_up,
  input  logic       SW_left,
  input  logic       SW_right,
  input  logic       SW_down,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [1:0] pac_Direction,
  output logic       dir_valid
);
  import pacman_pkg::dir_t;
  import pacman_pkg::BTN_UP;
  import pacman_pkg::BTN_LEFT;
  import pacman_pkg::BTN_RIGHT;
  import pacman_pkg::BTN_DOWN;

  logic [3:0] pins_s;
  logic [3:0] press_set_s;
  dir_t       dir_r, dir_s;
  logic       valid_r, valid_s;

  assign pins_s = {SW_down, SW_right, SW_left, SW_up};

  for (genvar i = 0; i < 4; i++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .CLK      (CLK),
      .RST_n    (RST_n),
      .pin      (pins_s[i]),
      .level    (btn_level[i]),
      .press    (btn_press[i]),
      .press_set(press_set_s[i])
    );
  end

  // Uses the pre-register press so the direction changes on the same edge as btn_press.
  always_comb begin
    dir_s   = dir_r;
    valid_s = valid_r | (|press_set_s);
    if (press_set_s[BTN_UP])         dir_s = UP;
    else if (press_set_s[BTN_LEFT])  dir_s = LEFT;
    else if (press_set_s[BTN_RIGHT]) dir_s = RIGHT;
    else if (press_set_s[BTN_DOWN])  dir_s = DOWN;
    else                             dir_s = dir_r;
  end

  // Direction and valid registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      dir_r   <= RIGHT;
      valid_r <= 1'b0;
    end else begin
      dir_r   <= dir_s;
      valid_r <= valid_s;
    end
  end

  assign pac_Direction = dir_r;
  assign dir_valid     = valid_r;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_btn_conditioner;

  logic       CLK;
  logic       RST_n;
  logic       SW_up, SW_left, SW_right, SW_down;
  logic [3:0] btn_level, btn_press;
  logic [1:0] pac_Direction;
  logic       dir_valid;
  logic [3:0] acc;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (16),
    .UP             (2'd0),
    .RIGHT          (2'd1),
    .LEFT           (2'd2),
    .DOWN           (2'd3)
  ) dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .SW_up        (SW_up),
    .SW_left      (SW_left),
    .SW_right     (SW_right),
    .SW_down      (SW_down),
    .btn_level    (btn_level),
    .btn_press    (btn_press),
    .pac_Direction(pac_Direction),
    .dir_valid    (dir_valid)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    chk_cnt++;
    if (obs === exp_v) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    RST_n = 1'b0;
    SW_up = 1'b0; SW_left = 1'b0; SW_right = 1'b0; SW_down = 1'b0;
    tick(3);
    check_val("rst_level", {4'd0, btn_level}, 8'h00);
    check_val("rst_press", {4'd0, btn_press}, 8'h00);
    check_val("rst_dir",   {6'd0, pac_Direction}, 8'h01);
    check_val("rst_valid", {7'd0, dir_valid}, 8'h00);
    RST_n = 1'b1;
    tick(20);
    check_val("idle_level", {4'd0, btn_level}, 8'h00);
    check_val("idle_press", {4'd0, btn_press}, 8'h00);
    check_val("idle_dir",   {6'd0, pac_Direction}, 8'h01);
    check_val("idle_valid", {7'd0, dir_valid}, 8'h00);

    // Up press: accepted 6 edges after the drive edge.
    SW_up = 1'b1;
    tick(5);
    check_val("up_early_level", {4'd0, btn_level}, 8'h00);
    check_val("up_early_press", {4'd0, btn_press}, 8'h00);
    tick(1);
    check_val("up_level", {4'd0, btn_level}, 8'h01);
    check_val("up_press", {4'd0, btn_press}, 8'h01);
    check_val("up_dir",   {6'd0, pac_Direction}, 8'h00);
    check_val("up_valid", {7'd0, dir_valid}, 8'h01);
    tick(1);
    check_val("up_press_once", {4'd0, btn_press}, 8'h00);
    check_val("up_level_hold", {4'd0, btn_level}, 8'h01);

    // 3-cycle glitch on left must be rejected.
    SW_left = 1'b1;
    tick(3);
    SW_left = 1'b0;
    acc = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      acc = acc | btn_press | (btn_level & 4'b0010);
    end
    check_val("glitch_left", {4'd0, acc & 4'b0010}, 8'h00);
    check_val("glitch_dir",  {6'd0, pac_Direction}, 8'h00);

    // Simultaneous left + down: left wins priority.
    SW_left = 1'b1; SW_down = 1'b1;
    tick(5);
    check_val("ld_early_press", {4'd0, btn_press}, 8'h00);
    tick(1);
    check_val("ld_press", {4'd0, btn_press}, 8'h0a);
    check_val("ld_level", {4'd0, btn_level}, 8'h0b);
    check_val("ld_dir",   {6'd0, pac_Direction}, 8'h02);
    tick(1);
    check_val("ld_press_once", {4'd0, btn_press}, 8'h00);

    // Release up with a 2-cycle bounce; level falls 6 edges after the final low.
    SW_up = 1'b0;
    acc = 4'b0000;
    tick(2);
    acc = acc | btn_press;
    SW_up = 1'b1;
    tick(2);
    acc = acc | btn_press;
    SW_up = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      acc = acc | btn_press;
    end
    check_val("rel_level_held", {7'd0, btn_level[0]}, 8'h01);
    tick(1);
    acc = acc | btn_press;
    check_val("rel_level_fall", {7'd0, btn_level[0]}, 8'h00);
    check_val("rel_no_press",   {7'd0, acc[0]}, 8'h00);

    // Reset in the middle of a right debounce; full debounce restarts after release.
    SW_right = 1'b1;
    tick(4);
    RST_n = 1'b0;
    SW_left = 1'b0; SW_down = 1'b0;
    #1;
    check_val("mid_rst_level", {4'd0, btn_level}, 8'h00);
    check_val("mid_rst_dir",   {6'd0, pac_Direction}, 8'h01);
    check_val("mid_rst_valid", {7'd0, dir_valid}, 8'h00);
    tick(3);
    RST_n = 1'b1;
    tick(5);
    check_val("right_early_press", {4'd0, btn_press}, 8'h00);
    check_val("right_early_valid", {7'd0, dir_valid}, 8'h00);
    tick(1);
    check_val("right_press", {4'd0, btn_press}, 8'h04);
    check_val("right_dir",   {6'd0, pac_Direction}, 8'h01);
    check_val("right_valid", {7'd0, dir_valid}, 8'h01);
    acc = 4'b0000;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      acc = acc | btn_press;
    end
    check_val("right_no_early_repeat", {4'd0, acc}, 8'h00);
    tick(1);
`ifdef BTN_AUTOREPEAT_EN
    check_val("right_repeat", {4'd0, btn_press}, 8'h04);
`else
    check_val("right_no_repeat", {4'd0, btn_press}, 8'h00);
`endif
    check_val("right_level_hold", {4'd0, btn_level}, 8'h04);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
